phys_free_list: RTL and testbench



---
 rtl/Purple_Jade_pkg.sv | 13 +
 rtl/phys_free_list_if.sv | 26 ++
 rtl/phys_free_list.sv | 96 +++++++++
 tb/tb_phys_free_list.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/Purple_Jade_pkg.sv
// Shared core parameters and helpers used by the rename-stage blocks
// (free list, ROB).
package Purple_Jade_pkg;

  localparam int NUM_PHYS_REG_DEF = 32;
  localparam int NUM_ARCH_REG_DEF = 16;

  // Circular pointer increment; depth need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/phys_free_list_if.sv
// Rename/commit-side bundle of the physical-register free list.
import Purple_Jade_pkg::*;

interface phys_free_list_if #(
  parameter int PR_W  = $clog2(NUM_PHYS_REG_DEF),
  parameter int CNT_W = $clog2(NUM_PHYS_REG_DEF - NUM_ARCH_REG_DEF + 1)
);
  logic             alloc_req_i;
  logic             alloc_valid_o;
  logic [PR_W-1:0]  alloc_reg_o;
  logic             rob_phys_valid_i;
  logic [PR_W-1:0]  rob_phys_reg_cl_i;
  logic             rob_phys_mispredict_i;
  logic [CNT_W-1:0] free_count_o;
  logic             error_o;

  modport master (
    output alloc_req_i, rob_phys_valid_i, rob_phys_reg_cl_i, rob_phys_mispredict_i,
    input  alloc_valid_o, alloc_reg_o, free_count_o, error_o
  );

  modport slave (
    input  alloc_req_i, rob_phys_valid_i, rob_phys_reg_cl_i, rob_phys_mispredict_i,
    output alloc_valid_o, alloc_reg_o, free_count_o, error_o
  );
endinterface

// File: rtl/phys_free_list.sv
// Physical-register free list: one grant per cycle from spec_head, frees pushed
// at tail on commit, one-cycle rollback of speculative grants to arch_head.
module phys_free_list
  import Purple_Jade_pkg::*;
#(
  parameter int NUM_PHYS_REG = NUM_PHYS_REG_DEF,
  parameter int NUM_ARCH_REG = NUM_ARCH_REG_DEF
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  phys_free_list_if.slave  bus
);
  localparam int PR_W  = $clog2(NUM_PHYS_REG);
  localparam int DEPTH = NUM_PHYS_REG - NUM_ARCH_REG;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PR_W-1:0]  fl_reg [DEPTH];
  logic [PTR_W-1:0] spec_head_reg, spec_head_next;
  logic [PTR_W-1:0] arch_head_reg, arch_head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] spec_count_reg, spec_count_next;
  logic [CNT_W-1:0] arch_count_reg;
  logic             error_reg, error_next;
  logic             alloc_valid, grant, commit;
  logic [CNT_W:0]   rollback_count;

  assign commit      = bus.rob_phys_valid_i;
  assign alloc_valid = (spec_count_reg != '0) && !bus.rob_phys_mispredict_i;
  assign grant       = bus.alloc_req_i && alloc_valid;

  always_comb begin
    spec_head_next  = spec_head_reg;
    arch_head_next  = arch_head_reg;
    tail_next       = tail_reg;
    spec_count_next = spec_count_reg;
    error_next      = error_reg;
    rollback_count  = {1'b0, arch_count_reg} + {{CNT_W{1'b0}}, commit};

    if (grant) spec_head_next = PTR_W'(ptr_inc(32'(spec_head_reg), DEPTH));
    if (commit) begin
      tail_next      = PTR_W'(ptr_inc(32'(tail_reg), DEPTH));
      arch_head_next = PTR_W'(ptr_inc(32'(arch_head_reg), DEPTH));
    end

    // A commit that is not matched by a same-cycle grant grows the list;
    // doing so when it is already full means nothing was outstanding.
    case ({grant, commit})
      2'b10:   spec_count_next = spec_count_reg - 1'b1;
      2'b01: begin
        if (spec_count_reg == FULL) error_next = 1'b1;
        else                        spec_count_next = spec_count_reg + 1'b1;
      end
      default: spec_count_next = spec_count_reg;
    endcase

    if (bus.rob_phys_mispredict_i) begin
      spec_head_next  = arch_head_next;
      spec_count_next = (rollback_count >= {1'b0, FULL}) ? FULL : rollback_count[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      spec_head_reg  <= '0;
      arch_head_reg  <= '0;
      tail_reg       <= '0;
      spec_count_reg <= FULL;
      arch_count_reg <= FULL;
      error_reg      <= 1'b0;
    end else begin
      spec_head_reg  <= spec_head_next;
      arch_head_reg  <= arch_head_next;
      tail_reg       <= tail_next;
      spec_count_reg <= spec_count_next;
      error_reg      <= error_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fl
      always_ff @(posedge clk_i) begin
        if (!reset_n_i)                                   fl_reg[gi] <= PR_W'(NUM_ARCH_REG + gi);
        else if (commit && (tail_reg == PTR_W'(gi)))      fl_reg[gi] <= bus.rob_phys_reg_cl_i;
      end
    end
  endgenerate

  assign bus.alloc_valid_o = alloc_valid;
  assign bus.alloc_reg_o   = fl_reg[spec_head_reg];
  assign bus.free_count_o  = spec_count_reg;
  assign bus.error_o       = error_reg;

endmodule

// File: tb/tb_phys_free_list.sv
// Directed-vector bench for phys_free_list with default parameters.
module tb_phys_free_list;

  logic clk_i = 1'b0;
  logic reset_n_i;
  int   n_vec = 0;
  int   n_miss = 0;

  phys_free_list_if #(.PR_W(5), .CNT_W(5)) bus ();

  phys_free_list dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.alloc_req_i           = 1'b0;
    bus.rob_phys_valid_i      = 1'b0;
    bus.rob_phys_reg_cl_i     = '0;
    bus.rob_phys_mispredict_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n_i = 1'b0;
    step();
    reset_n_i = 1'b1;
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_valid"}, 32'(bus.alloc_valid_o), 1);
    check_val({tag, "_reg"},   32'(bus.alloc_reg_o),   16);
    check_val({tag, "_count"}, 32'(bus.free_count_o),  16);
    check_val({tag, "_err"},   32'(bus.error_o),       0);
  endtask

  int exp_reg;

  initial begin
    reset_n_i = 1'b1;
    do_reset();
    check_reset_state("reset");

    // Drain all 16 free registers, then a stalled 17th request
    for (int k = 0; k < 16; k++) begin
      bus.alloc_req_i = 1'b1;
      #1;
      check_val($sformatf("drain_reg%0d", k), 32'(bus.alloc_reg_o), 32'(16 + k));
      step();
    end
    check_val("empty_valid", 32'(bus.alloc_valid_o), 0);
    check_val("empty_count", 32'(bus.free_count_o),  0);
    step();
    check_val("stall_count", 32'(bus.free_count_o), 0);
    check_val("stall_err",   32'(bus.error_o),      0);

    // Commit from empty: freed register not granted in the write cycle
    bus.rob_phys_valid_i  = 1'b1;
    bus.rob_phys_reg_cl_i = 5'd5;
    #1;
    check_val("commit_empty_valid", 32'(bus.alloc_valid_o), 0);
    step();
    idle();
    #1;
    check_val("freed_valid", 32'(bus.alloc_valid_o), 1);
    check_val("freed_reg",   32'(bus.alloc_reg_o),   5);
    check_val("freed_count", 32'(bus.free_count_o),  1);

    // 4 grants, one commit, then rollback
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.alloc_req_i = 1'b1;
      #1;
      check_val($sformatf("spec_reg%0d", k), 32'(bus.alloc_reg_o), 32'(16 + k));
      step();
    end
    idle();
    bus.rob_phys_valid_i  = 1'b1;
    bus.rob_phys_reg_cl_i = 5'd3;
    step();
    idle();
    #1;
    check_val("pre_rb_count", 32'(bus.free_count_o), 13);
    bus.rob_phys_mispredict_i = 1'b1;
    #1;
    check_val("rb_cycle_valid", 32'(bus.alloc_valid_o), 0);
    step();
    idle();
    #1;
    check_val("rb_reg",   32'(bus.alloc_reg_o),  17);
    check_val("rb_count", 32'(bus.free_count_o), 16);
    for (int k = 0; k < 16; k++) begin
      bus.alloc_req_i = 1'b1;
      #1;
      exp_reg = (k < 15) ? 17 + k : 3;
      check_val($sformatf("rb_order%0d", k), 32'(bus.alloc_reg_o), 32'(exp_reg));
      step();
    end
    idle();

    // 40 cycles of same-cycle grant + commit; pointers wrap twice
    do_reset();
    for (int k = 0; k < 40; k++) begin
      bus.alloc_req_i       = 1'b1;
      bus.rob_phys_valid_i  = 1'b1;
      bus.rob_phys_reg_cl_i = 5'((k * 7) % 32);
      #1;
      exp_reg = (k < 16) ? 16 + k : ((k - 16) * 7) % 32;
      check_val($sformatf("gc_reg%0d", k), 32'(bus.alloc_reg_o), 32'(exp_reg));
      step();
      check_val($sformatf("gc_count%0d", k), 32'(bus.free_count_o), 16);
    end
    idle();
    #1;
    check_val("gc_err", 32'(bus.error_o), 0);

    // Mispredict together with a request
    do_reset();
    bus.alloc_req_i = 1'b1;
    step();
    step();
    bus.rob_phys_mispredict_i = 1'b1;
    #1;
    check_val("mp_req_valid", 32'(bus.alloc_valid_o), 0);
    step();
    idle();
    #1;
    check_val("mp_req_reg",   32'(bus.alloc_reg_o),  16);
    check_val("mp_req_count", 32'(bus.free_count_o), 16);

    // Commit with nothing outstanding: sticky error until reset
    do_reset();
    bus.rob_phys_valid_i  = 1'b1;
    bus.rob_phys_reg_cl_i = 5'd9;
    step();
    idle();
    #1;
    check_val("err_set",   32'(bus.error_o),      1);
    check_val("err_count", 32'(bus.free_count_o), 16);
    step();
    step();
    check_val("err_held", 32'(bus.error_o), 1);
    do_reset();
    check_reset_state("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
